mac_header_extractor: RTL and testbench

//   Ingress stage directly upstream of the MAC table. Parses each incoming frame byte stream, assembles
//   48-bit DA and SA, and folds each to a pMAC_W-bit key. Issues one learn/lookup strobe per valid

---
 rtl/mac_sw_pkg.sv | 32 +++
 rtl/mac_fold_hash.sv | 13 +
 rtl/mac_header_extractor.sv | 168 ++++++++++++++++
 tb/tb_mac_header_extractor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_sw_pkg.sv
// Shared definitions for the MAC header extractor: parser states, header geometry and the
// address-folding function used to derive table keys.
package mac_sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DA   = 2'd1,
        ST_SA   = 2'd2,
        ST_TAIL = 2'd3
    } hdr_state_e;

    localparam int MAC_BITS  = 48;
    localparam int MAC_BYTES = 6;
    localparam int HDR_BYTES = 12;

    // XOR of all w-bit slices of a, lowest slice first; the top slice is implicitly zero-padded.
    function automatic logic [MAC_BITS-1:0] mac_fold(input logic [MAC_BITS-1:0] a,
                                                     input int unsigned w);
        logic [MAC_BITS-1:0] acc;
        logic [MAC_BITS-1:0] rem;
        logic [MAC_BITS-1:0] mask;
        acc  = '0;
        rem  = a;
        mask = (48'd1 << w) - 48'd1;
        for (int i = 0; i < MAC_BITS; i++) begin
            acc = acc ^ (rem & mask);
            rem = rem >> w;
        end
        return acc;
    endfunction

endpackage

// File: rtl/mac_fold_hash.sv
// Combinational fold of a 48-bit MAC address down to a pMAC_W-bit table key.
module mac_fold_hash
    import mac_sw_pkg::*;
#(
    parameter int pMAC_W = 14
) (
    input  logic [47:0]       i_mac,
    output logic [pMAC_W-1:0] o_key
);

    assign o_key = pMAC_W'(mac_fold(i_mac, pMAC_W));

endmodule

// File: rtl/mac_header_extractor.sv
// Parses frame bytes into DA/SA, folds them to table keys and strobes one learn/lookup per header.
// Optional statistics counters are built when MAC_HDR_STATS_EN is defined.
module mac_header_extractor
    import mac_sw_pkg::*;
#(
    parameter int pADRESS = 2,
    parameter int pMAC_W  = 14,
    parameter int pCNT_W  = 16
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [pADRESS-1:0] i_port_num,
    input  logic [7:0]         i_data,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic               i_eof,
    output logic               o_write_enable,
    output logic [pADRESS-1:0] o_port_num,
    output logic [pMAC_W-1:0]  o_MAC_SA,
    output logic [pMAC_W-1:0]  o_MAC_DA,
`ifdef MAC_HDR_STATS_EN
    output logic [pCNT_W-1:0]  o_frame_cnt,
    output logic [pCNT_W-1:0]  o_runt_cnt,
`endif
    output logic               o_runt
);

    localparam logic [3:0] LAST_DA  = 4'(MAC_BYTES - 1);
    localparam logic [3:0] LAST_HDR = 4'(HDR_BYTES - 1);

    hdr_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [47:0]        da_q, da_d;
    logic [47:0]        sa_q, sa_d;
    logic [pADRESS-1:0] port_q, port_d;
    logic               hdr_done, runt_det;

    logic               we_q, we_d;
    logic               runt_q, runt_d;
    logic [pADRESS-1:0] port_out_q, port_out_d;
    logic [pMAC_W-1:0]  mac_sa_q, mac_sa_d;
    logic [pMAC_W-1:0]  mac_da_q, mac_da_d;
    logic [pMAC_W-1:0]  sa_key, da_key;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            da_q       <= '0;
            sa_q       <= '0;
            port_q     <= '0;
            we_q       <= 1'b0;
            runt_q     <= 1'b0;
            port_out_q <= '0;
            mac_sa_q   <= '0;
            mac_da_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            da_q       <= da_d;
            sa_q       <= sa_d;
            port_q     <= port_d;
            we_q       <= we_d;
            runt_q     <= runt_d;
            port_out_q <= port_out_d;
            mac_sa_q   <= mac_sa_d;
            mac_da_q   <= mac_da_d;
        end
    end

    // NOTE: every signal gets a hold default up front so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        da_d     = da_q;
        sa_d     = sa_q;
        port_d   = port_q;
        hdr_done = 1'b0;
        runt_det = 1'b0;
        if (i_valid) begin
            if (i_sof) begin
                // A sof always restarts; an unfinished header (or a one-byte frame) is a runt.
                runt_det = (state_q == ST_DA) || (state_q == ST_SA) || i_eof;
                da_d     = {da_q[39:0], i_data};
                port_d   = i_port_num;
                cnt_d    = i_eof ? 4'd0 : 4'd1;
                state_d  = i_eof ? ST_IDLE : ST_DA;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_DA: begin
                        da_d = {da_q[39:0], i_data};
                        if (i_eof) begin
                            runt_det = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q == LAST_DA) state_d = ST_SA;
                        end
                    end
                    ST_SA: begin
                        sa_d = {sa_q[39:0], i_data};
                        if (cnt_q == LAST_HDR) begin
                            hdr_done = 1'b1;
                            cnt_d    = '0;
                            state_d  = i_eof ? ST_IDLE : ST_TAIL;
                        end else if (i_eof) begin
                            runt_det = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    ST_TAIL: if (i_eof) state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // SA key is folded from sa_d so the final SA byte is included on the cycle it arrives.
    mac_fold_hash #(.pMAC_W(pMAC_W)) u_fold_sa (.i_mac(sa_d), .o_key(sa_key));
    mac_fold_hash #(.pMAC_W(pMAC_W)) u_fold_da (.i_mac(da_q), .o_key(da_key));

    always_comb begin
        we_d       = hdr_done;
        runt_d     = runt_det;
        port_out_d = hdr_done ? port_q : port_out_q;
        mac_sa_d   = hdr_done ? sa_key : mac_sa_q;
        mac_da_d   = hdr_done ? da_key : mac_da_q;
    end

    assign o_write_enable = we_q;
    assign o_runt         = runt_q;
    assign o_port_num     = port_out_q;
    assign o_MAC_SA       = mac_sa_q;
    assign o_MAC_DA       = mac_da_q;

`ifdef MAC_HDR_STATS_EN
    logic [pCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [pCNT_W-1:0] runt_cnt_q, runt_cnt_d;

    always_ff @(posedge iclk) begin
        if (irst) begin
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        if (we_q && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
        if (runt_q && (runt_cnt_q != '1)) runt_cnt_d = runt_cnt_q + 1'b1;
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_runt_cnt  = runt_cnt_q;
`endif

endmodule

// File: tb/tb_mac_header_extractor.sv
// Scoreboard bench for mac_header_extractor: stimulus pushes expected strobes/runts, a monitor pops them.
module tb_mac_header_extractor;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic [1:0]  i_port_num = '0;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    logic        i_eof = 1'b0;
    logic        o_write_enable;
    logic [1:0]  o_port_num;
    logic [13:0] o_MAC_SA;
    logic [13:0] o_MAC_DA;
    logic        o_runt;
`ifdef MAC_HDR_STATS_EN
    logic [15:0] o_frame_cnt;
    logic [15:0] o_runt_cnt;
`endif

    mac_header_extractor dut (
        .iclk           (iclk),
        .irst           (irst),
        .i_port_num     (i_port_num),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .i_sof          (i_sof),
        .i_eof          (i_eof),
        .o_write_enable (o_write_enable),
        .o_port_num     (o_port_num),
        .o_MAC_SA       (o_MAC_SA),
        .o_MAC_DA       (o_MAC_DA),
`ifdef MAC_HDR_STATS_EN
        .o_frame_cnt    (o_frame_cnt),
        .o_runt_cnt     (o_runt_cnt),
`endif
        .o_runt         (o_runt)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        bit          is_runt;
        logic [1:0]  port;
        logic [13:0] da;
        logic [13:0] sa;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_strobe(input string name, input logic [1:0] port,
                               input logic [13:0] da, input logic [13:0] sa);
        exp_t e;
        e.is_runt = 1'b0; e.port = port; e.da = da; e.sa = sa; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic push_runt(input string name);
        exp_t e;
        e.is_runt = 1'b1; e.port = '0; e.da = '0; e.sa = '0; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: every runt/strobe the DUT shows must match the next scoreboard entry.
    always @(negedge iclk) begin
        if (!irst) begin
            if (o_runt) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_runt: got o_runt=1 expected no event");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_kind_runt"}, 48'(e.is_runt), 48'd1);
                end
            end
            if (o_write_enable) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_strobe: got o_write_enable=1 expected no event");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_kind_strobe"}, 48'(e.is_runt), 48'd0);
                    check({e.name, "_port"}, 48'(o_port_num), 48'(e.port));
                    check({e.name, "_da"},   48'(o_MAC_DA),   48'(e.da));
                    check({e.name, "_sa"},   48'(o_MAC_SA),   48'(e.sa));
                end
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic sof, input logic eof,
                         input logic [1:0] port);
        i_valid = 1'b1; i_data = b; i_sof = sof; i_eof = eof; i_port_num = port;
        @(posedge iclk); #1;
        i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0; i_data = 8'h00;
    endtask

    task automatic idle_cycle();
        i_valid = 1'b0;
        @(posedge iclk); #1;
    endtask

    // cut>0: send only cut bytes with no eof (frame is then interrupted by the caller).
    task automatic send_frame(input logic [1:0] port, input logic [47:0] da,
                              input logic [47:0] sa, input int len, input bit gap,
                              input int cut);
        int n;
        n = (cut > 0) ? cut : len;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            if (i < 6)       b = da[47 - 8*i -: 8];
            else if (i < 12) b = sa[47 - 8*(i-6) -: 8];
            else             b = 8'(i);
            if (gap && i < 12) idle_cycle();
            // Non-sof bytes carry a different port to show it is sampled on sof only.
            drive(b, i == 0, (cut == 0) && (i == len - 1), (i == 0) ? port : ~port);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_we"},   48'(o_write_enable), 48'd0);
        check({name, "_runt"}, 48'(o_runt),         48'd0);
        check({name, "_port"}, 48'(o_port_num),     48'd0);
        check({name, "_da"},   48'(o_MAC_DA),       48'd0);
        check({name, "_sa"},   48'(o_MAC_SA),       48'd0);
    endtask

    initial begin
        irst = 1'b1;
        @(posedge iclk); #1;
        check_outputs_zero("reset");
        irst = 1'b0;

        // 1: basic 64-byte frame
        push_strobe("t1", 2'd2, 14'h0001, 14'h0002);
        send_frame(2'd2, 48'h0000_0000_0001, 48'h0000_0000_0002, 64, 1'b0, 0);
        idle_cycle();
        check("t1_hold_port", 48'(o_port_num), 48'd2);
        check("t1_hold_da",   48'(o_MAC_DA),   48'h0001);

        // 2: all-ones DA folds to 3FC0; SA 123456789ABC folds to 201F
        push_strobe("t2", 2'd1, 14'h3FC0, 14'h201F);
        send_frame(2'd1, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 20, 1'b0, 0);

        // 3: 7-byte frame is a runt
        push_runt("t3");
        send_frame(2'd3, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 7, 1'b0, 0);
        idle_cycle();

        // 4: exact 12-byte frames back to back
        push_strobe("t4a", 2'd0, 14'h0001, 14'h0020);
        send_frame(2'd0, 48'h0000_0000_4000, 48'h8000_0000_0000, 12, 1'b0, 0);
        push_strobe("t4b", 2'd1, 14'h0003, 14'h0004);
        send_frame(2'd1, 48'h0000_0000_0003, 48'h0000_0001_0000, 12, 1'b0, 0);
        idle_cycle();

        // 5: gapped header, then a frame cut at byte 9 by a new sof on port 3
        push_strobe("t5a", 2'd2, 14'h0001, 14'h0002);
        send_frame(2'd2, 48'h0000_0000_0001, 48'h0000_0000_0002, 16, 1'b1, 0);
        push_runt("t5_restart");
        push_strobe("t5b", 2'd3, 14'h3FC0, 14'h201F);
        send_frame(2'd1, 48'h0000_0000_0009, 48'h0000_0000_0007, 0, 1'b0, 8);
        send_frame(2'd3, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 14, 1'b0, 0);
        idle_cycle();
        idle_cycle();
`ifdef MAC_HDR_STATS_EN
        check("stats_frames", 48'(o_frame_cnt), 48'd6);
        check("stats_runts",  48'(o_runt_cnt),  48'd2);
`endif

        // 6: reset at byte 5 discards the frame; bytes without sof are ignored afterwards
        send_frame(2'd1, 48'hAAAA_BBBB_CCCC, 48'h1111_2222_3333, 0, 1'b0, 5);
        irst = 1'b1;
        @(posedge iclk); #1;
        irst = 1'b0;
        check_outputs_zero("t6_reset");
        drive(8'hAA, 1'b0, 1'b0, 2'd3);
        drive(8'hBB, 1'b0, 1'b0, 2'd3);
        drive(8'hCC, 1'b0, 1'b1, 2'd3);
        push_strobe("t6", 2'd2, 14'h0001, 14'h0002);
        send_frame(2'd2, 48'h0000_0000_0001, 48'h0000_0000_0002, 12, 1'b0, 0);
        repeat (4) idle_cycle();

        check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
